// File: rtl/fft_peak_finder_if.sv
// Packet stream from fft_int into the peak finder, plus the peak/error results.
// master = the FFT side (drives sink_*), slave = the peak finder.
interface fft_peak_finder_if #(
    parameter int POW        = 12,
    parameter int DATA_WIDTH = 26
);
    logic                         sink_sop;
    logic                         sink_eop;
    logic                         sink_valid;
    logic signed [DATA_WIDTH-1:0] sink_Re;
    logic signed [DATA_WIDTH-1:0] sink_Im;
    logic                         peak_valid;
    logic [POW-1:0]               peak_bin;
    logic [2*DATA_WIDTH-1:0]      peak_mag;
    logic signed [DATA_WIDTH-1:0] peak_Re;
    logic signed [DATA_WIDTH-1:0] peak_Im;
    logic                         error;

    modport master (
        output sink_sop, sink_eop, sink_valid, sink_Re, sink_Im,
        input  peak_valid, peak_bin, peak_mag, peak_Re, peak_Im, error
    );

    modport slave (
        input  sink_sop, sink_eop, sink_valid, sink_Re, sink_Im,
        output peak_valid, peak_bin, peak_mag, peak_Re, peak_Im, error
    );
endinterface

// File: rtl/fft_peak_finder.sv
// Finds the strongest positive-frequency bin (1..N/2-1) of each FFT packet and
// flags malformed sop/eop framing. Three-stage pipeline: capture, |X|^2, compare.
module fft_peak_finder #(
    parameter int POW        = 12,
    parameter int DATA_WIDTH = 26
) (
    input logic               clk,
    input logic               aclr,
    fft_peak_finder_if.slave  bus
);
    localparam logic [POW-1:0] LAST = '1;
    localparam logic [POW-1:0] ONE  = {{(POW-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, FRAME} state_t;

    state_t         r_state, w_state_n;
    logic [POW:0]   r_cnt, w_cnt_n;
    logic           w_err, w_good, w_take;
    logic [POW-1:0] w_bin;
    logic           w_srch, w_first;

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
        end
    end

    // sop always restarts a frame; in FRAME it also abandons the old one
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_take    = 1'b0;
        w_err     = 1'b0;
        w_good    = 1'b0;
        w_bin     = '0;
        if (bus.sink_valid) begin
            if (bus.sink_sop) begin
                w_take    = 1'b1;
                w_cnt_n   = {{POW{1'b0}}, 1'b1};
                w_state_n = FRAME;
                if (r_state == FRAME) w_err = 1'b1;
                if (bus.sink_eop) begin
                    w_err     = 1'b1;
                    w_state_n = IDLE;
                    w_cnt_n   = '0;
                end
            end else if (r_state == FRAME) begin
                w_take  = 1'b1;
                w_bin   = r_cnt[POW-1:0];
                w_cnt_n = r_cnt + 1'b1;
                if (bus.sink_eop || w_bin == LAST) begin
                    w_state_n = IDLE;
                    w_cnt_n   = '0;
                    if (bus.sink_eop && w_bin == LAST) w_good = 1'b1;
                    else                               w_err  = 1'b1;
                end
            end
        end
    end

    assign w_srch  = w_take && !w_bin[POW-1] && (w_bin != '0);
    assign w_first = w_take && (w_bin == ONE);

    // stage 1: capture
    logic signed [DATA_WIDTH-1:0] r_s1_re, r_s1_im;
    logic [POW-1:0]               r_s1_bin;
    logic                         r_s1_srch, r_s1_first, r_s1_good, r_s1_err;

    // stage 2: magnitude
    logic signed [DATA_WIDTH-1:0] r_s2_re, r_s2_im;
    logic [POW-1:0]               r_s2_bin;
    logic [2*DATA_WIDTH-1:0]      r_s2_mag;
    logic                         r_s2_srch, r_s2_first, r_s2_good;

    // stage 3: running best
    logic signed [DATA_WIDTH-1:0] r_best_re, r_best_im;
    logic [POW-1:0]               r_best_bin;
    logic [2*DATA_WIDTH-1:0]      r_best_mag;
    logic                         r_s3_good;

    logic signed [DATA_WIDTH-1:0] r_peak_re, r_peak_im;
    logic [POW-1:0]               r_peak_bin;
    logic [2*DATA_WIDTH-1:0]      r_peak_mag;
    logic                         r_peak_valid, r_error;

    logic signed [2*DATA_WIDTH-1:0] w_re_sq, w_im_sq;
    assign w_re_sq = r_s1_re * r_s1_re;
    assign w_im_sq = r_s1_im * r_s1_im;

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_s1_re    <= '0;
            r_s1_im    <= '0;
            r_s1_bin   <= '0;
            r_s1_srch  <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_good  <= 1'b0;
            r_s1_err   <= 1'b0;
            r_s2_re    <= '0;
            r_s2_im    <= '0;
            r_s2_bin   <= '0;
            r_s2_mag   <= '0;
            r_s2_srch  <= 1'b0;
            r_s2_first <= 1'b0;
            r_s2_good  <= 1'b0;
            r_best_re  <= '0;
            r_best_im  <= '0;
            r_best_bin <= ONE;
            r_best_mag <= '0;
            r_s3_good  <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_s1_re    <= bus.sink_Re;
            r_s1_im    <= bus.sink_Im;
            r_s1_bin   <= w_bin;
            r_s1_srch  <= w_srch;
            r_s1_first <= w_first;
            r_s1_good  <= w_good;
            r_s1_err   <= w_err;
            r_error    <= r_s1_err;

            r_s2_re    <= r_s1_re;
            r_s2_im    <= r_s1_im;
            r_s2_bin   <= r_s1_bin;
            r_s2_mag   <= $unsigned(w_re_sq) + $unsigned(w_im_sq);
            r_s2_srch  <= r_s1_srch;
            r_s2_first <= r_s1_first;
            r_s2_good  <= r_s1_good;

            // bin 1 unconditionally reseeds the best; strict > keeps the lower bin on ties
            if (r_s2_srch && (r_s2_first || r_s2_mag > r_best_mag)) begin
                r_best_re  <= r_s2_re;
                r_best_im  <= r_s2_im;
                r_best_bin <= r_s2_bin;
                r_best_mag <= r_s2_mag;
            end
            r_s3_good <= r_s2_good;
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_peak_valid <= 1'b0;
            r_peak_bin   <= '0;
            r_peak_mag   <= '0;
            r_peak_re    <= '0;
            r_peak_im    <= '0;
        end else begin
            r_peak_valid <= r_s3_good;
            if (r_s3_good) begin
                r_peak_bin <= r_best_bin;
                r_peak_mag <= r_best_mag;
                r_peak_re  <= r_best_re;
                r_peak_im  <= r_best_im;
            end
        end
    end

    assign bus.peak_valid = r_peak_valid;
    assign bus.peak_bin   = r_peak_bin;
    assign bus.peak_mag   = r_peak_mag;
    assign bus.peak_Re    = r_peak_re;
    assign bus.peak_Im    = r_peak_im;
    assign bus.error      = r_error;
endmodule

// File: tb/tb_fft_peak_finder.sv
// Directed packets for fft_peak_finder; expected peaks/errors go into a queue
// that a negedge monitor drains whenever peak_valid or error fires.
module tb_fft_peak_finder;
    localparam int POW = 12;
    localparam int DW  = 26;
    localparam int N   = 1 << POW;

    logic clk  = 1'b0;
    logic aclr = 1'b1;
    always #5 clk = ~clk;

    fft_peak_finder_if #(.POW(POW), .DATA_WIDTH(DW)) bus ();
    fft_peak_finder #(.POW(POW), .DATA_WIDTH(DW)) dut (.clk(clk), .aclr(aclr), .bus(bus));

    typedef struct {
        bit                   is_err;
        int                   cyc;
        logic [POW-1:0]       bin;
        logic [2*DW-1:0]      mag;
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic signed [DW-1:0] mre [N];
    logic signed [DW-1:0] mim [N];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (!aclr && (bus.peak_valid || bus.error)) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out: cyc=%0d valid=%b error=%b, want no output", cyc, bus.peak_valid, bus.error);
            end else begin
                e = q.pop_front();
                if (e.is_err != bus.error || e.is_err == bus.peak_valid || e.cyc != cyc) begin
                    bad++;
                    $display("FAIL event: got valid=%b error=%b at cyc %0d, want is_err=%b at cyc %0d",
                             bus.peak_valid, bus.error, cyc, e.is_err, e.cyc);
                end else if (!e.is_err && (bus.peak_bin !== e.bin || bus.peak_mag !== e.mag ||
                                           bus.peak_Re !== e.re || bus.peak_Im !== e.im)) begin
                    bad++;
                    $display("FAIL peak: got bin=%0d mag=%0d re=%0d im=%0d, want bin=%0d mag=%0d re=%0d im=%0d",
                             bus.peak_bin, bus.peak_mag, bus.peak_Re, bus.peak_Im, e.bin, e.mag, e.re, e.im);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 64'(bus.peak_valid), 64'd0);
        chk({tag, "_error"}, 64'(bus.error), 64'd0);
        chk({tag, "_bin"}, 64'(bus.peak_bin), 64'd0);
        chk({tag, "_mag"}, 64'(bus.peak_mag), 64'd0);
        chk({tag, "_re"}, 64'($unsigned(bus.peak_Re)), 64'd0);
        chk({tag, "_im"}, 64'($unsigned(bus.peak_Im)), 64'd0);
    endtask

    task automatic clear();
        for (int i = 0; i < N; i++) begin
            mre[i] = '0;
            mim[i] = '0;
        end
    endtask

    // idle slots carry random sop/eop to show they are ignored without valid
    task automatic beat(input bit sop, input bit eop, input logic signed [DW-1:0] re,
                        input logic signed [DW-1:0] im, input bit gaps);
        if (gaps) begin
            while ($urandom_range(0, 9) < 3) begin
                @(posedge clk); #1;
                bus.sink_valid = 1'b0;
                bus.sink_sop   = 1'($urandom_range(0, 1));
                bus.sink_eop   = 1'($urandom_range(0, 1));
            end
        end
        @(posedge clk); #1;
        bus.sink_valid = 1'b1;
        bus.sink_sop   = sop;
        bus.sink_eop   = eop;
        bus.sink_Re    = re;
        bus.sink_Im    = im;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.sink_valid = 1'b0;
            bus.sink_sop   = 1'b0;
            bus.sink_eop   = 1'b0;
        end
    endtask

    task automatic push_err();
        exp_t e;
        e = '{is_err: 1'b1, cyc: cyc + 2, bin: '0, mag: '0, re: '0, im: '0};
        q.push_back(e);
    endtask

    task automatic push_peak(input logic [POW-1:0] b, input logic [2*DW-1:0] m,
                             input logic signed [DW-1:0] r, input logic signed [DW-1:0] i);
        exp_t e;
        e = '{is_err: 1'b0, cyc: cyc + 4, bin: b, mag: m, re: r, im: i};
        q.push_back(e);
    endtask

    // last_kind: 0 nothing expected, 1 peak, 2 error on the final beat
    task automatic pkt(input int len, input bit eop_last, input bit gaps, input bit err_first,
                       input int last_kind, input logic [POW-1:0] b, input logic [2*DW-1:0] m,
                       input logic signed [DW-1:0] r, input logic signed [DW-1:0] i);
        for (int k = 0; k < len; k++) begin
            beat(k == 0, eop_last && k == len - 1, mre[k], mim[k], gaps);
            if (k == 0 && err_first) push_err();
            if (k == len - 1 && last_kind == 1) push_peak(b, m, r, i);
            if (k == len - 1 && last_kind == 2) push_err();
        end
    endtask

    initial begin
        bus.sink_valid = 1'b0;
        bus.sink_sop   = 1'b0;
        bus.sink_eop   = 1'b0;
        bus.sink_Re    = '0;
        bus.sink_Im    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;
        aclr = 1'b0;

        // single tone at bin 200; next packet follows back-to-back
        clear();
        mre[200] = 1000;
        pkt(N, 1, 0, 0, 1, 12'd200, 52'd1000000, 26'sd1000, 26'sd0);

        // DC and negative-frequency bins ignored; tie goes to the lower bin
        clear();
        mim[10] = -300; mim[20] = -300;
        mre[0] = (1 << 25) - 1;
        mre[3000] = 5000; mim[3000] = 5000;
        pkt(N, 1, 0, 0, 1, 12'd10, 52'd90000, 26'sd0, -26'sd300);

        // most negative value on both axes
        clear();
        mre[7] = -(1 << 25); mim[7] = -(1 << 25);
        pkt(N, 1, 0, 0, 1, 12'd7, 52'd1 << 51, -(26'sd1 << 25), -(26'sd1 << 25));

        // early eop, then a good packet with a tie against bin 1
        clear();
        pkt(101, 1, 0, 0, 2, '0, '0, '0, '0);
        mre[1] = 3; mim[1] = 4; mre[500] = -4; mim[500] = 3;
        pkt(N, 1, 0, 0, 1, 12'd1, 52'd25, 26'sd3, 26'sd4);

        // missing eop on the last bin, then sop+eop together while idle
        clear();
        pkt(N, 0, 0, 0, 2, '0, '0, '0, '0);
        beat(1'b1, 1'b1, '0, '0, 1'b0);
        push_err();

        // sop mid-frame restarts; gapped and gapless copies must agree
        mre[2047] = 1; mim[2047] = 1; mre[2048] = 100; mre[0] = 50;
        pkt(500, 0, 0, 0, 0, '0, '0, '0, '0);
        pkt(N, 1, 1, 1, 1, 12'd2047, 52'd2, 26'sd1, 26'sd1);
        pkt(N, 1, 0, 0, 1, 12'd2047, 52'd2, 26'sd1, 26'sd1);

        // reset mid-frame: everything cleared, nothing reported
        clear();
        mre[9] = 77;
        pkt(2000, 0, 0, 0, 0, '0, '0, '0, '0);
        @(posedge clk); #1;
        aclr = 1'b1;
        bus.sink_valid = 1'b0;
        bus.sink_sop   = 1'b0;
        bus.sink_eop   = 1'b0;
        @(negedge clk);
        chk_zero("aclr");
        @(posedge clk); #1;
        aclr = 1'b0;
        clear();
        pkt(N, 1, 0, 0, 1, 12'd1, 52'd0, 26'sd0, 26'sd0);

        idle(10);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fft_peak_finder.md
# fft_peak_finder

Consumes the frequency-domain packet stream emitted by `fft_int` (`source_*` side) and reports, once per packet, the strongest positive-frequency bin: its index, its squared magnitude and its complex value. It sits directly downstream of `fft_int` and is the receiving end of the same sop/eop/valid packet protocol that feeds the FFT. It also checks packet framing and flags malformed packets.

## Interface

Parameters:
- POW, 12, packet length N = 2**POW beats.
- DATA_WIDTH, 26, width of signed input Re/Im; equals `fft_int` RES_WIDTH.

Ports:
- clk  in  1  processing clock, all logic on rising edge.
- aclr  in  1  reset; asynchronous, active-high. One clock domain only.
- sink_sop  in  1  start of packet; qualified by sink_valid.
- sink_eop  in  1  end of packet; qualified by sink_valid.
- sink_valid  in  1  beat valid; no backpressure, every valid beat is accepted.
- sink_Re  in  DATA_WIDTH  signed real part.
- sink_Im  in  DATA_WIDTH  signed imaginary part.
- peak_valid  out  1  one-cycle pulse, result outputs valid.
- peak_bin  out  POW  index of strongest bin.
- peak_mag  out  2*DATA_WIDTH  unsigned Re²+Im² of that bin.
- peak_Re  out  DATA_WIDTH  real part of that bin.
- peak_Im  out  DATA_WIDTH  imaginary part of that bin.
- error  out  1  one-cycle pulse on framing error.

## Operation

- Beat = cycle with sink_valid=1. sop/eop ignored when sink_valid=0.
- States: IDLE (waiting for sop), FRAME (collecting). Bin counter cnt, POW+1 bits.
- IDLE: valid beat with sop → FRAME, beat is bin 0, cnt=1. Valid beats without sop are discarded silently.
- FRAME: each valid beat is bin cnt, cnt increments.
  - eop on beat with bin index N-1 → frame good, result issued, → IDLE.
  - eop on any other bin index → error pulse, no result, → IDLE.
  - sop mid-frame → error pulse, old frame abandoned, this beat restarts a new frame as bin 0 (stay FRAME).
  - beat index N-1 without eop → error pulse, no result, → IDLE.
  - sop and eop on the same beat: treated as sop (restart) then eop on bin 0 → error, → IDLE.
- Search range: bins 1 .. N/2-1 only (DC and negative frequencies excluded). Other bins still counted for framing.
- Magnitude: Re²+Im² exact, signed products, unsigned 2*DATA_WIDTH sum; no overflow possible (max 2^(2·DATA_WIDTH-1)).
- Compare: strictly greater replaces best; ties keep the lower bin. Best cleared to mag 0, bin 1, Re/Im of bin 1 at each frame start (bin 1 always loads).
- Result outputs hold their last value until the next peak_valid.

## Timing

- Pipeline: stage 1 registers Re, Im, bin, flags; stage 2 registers magnitude; stage 3 compare/update best.
- peak_valid rises 3 clock cycles after the rising edge sampling the good eop beat; high exactly one cycle.
- error rises 1 cycle after the edge sampling the offending beat; one cycle.
- Back-to-back packets (sop on the cycle after eop) fully supported; sink_valid gaps inside a frame stall the count only.
- Reset: state IDLE, cnt 0, pipeline flushed; peak_valid 0, error 0, peak_bin 0, peak_mag 0, peak_Re 0, peak_Im 0. aclr mid-frame discards the frame with no result and no error; in-flight pipeline results are dropped.

## Test plan

- POW=12, bin 200 = (1000,0), all others 0, continuous valid → peak_valid 3 cycles after eop, peak_bin=200, peak_mag=1000000, peak_Re=1000, peak_Im=0.
- Bins 10 and 20 both (0,-300), bin 0 (DC) = (2^25-1,0), bin 3000 = (5000,5000) → peak_bin=10, peak_mag=90000 (DC and negative-frequency bins ignored, tie to lower).
- Bin 7 = (-2^25,-2^25) → peak_mag=2^51, peak_Re=peak_Im=-2^25 (extreme width).
- eop at beat 100 → error pulse 1 cycle later, no peak_valid; following correct packet reports normally.
- sop at beat 500 of a frame, then 4096 beats with eop → one error pulse, then one peak_valid for the restarted frame; random sink_valid gaps (30 % low) give identical result to gapless stimulus.
- aclr pulsed at beat 2000 → all outputs 0, no peak_valid, no error; next full packet reports correctly.
